// File: rtl/dom_prep_pkg.sv
// Shared constants, state type and LFSR step function for the DOM share-preparation block.
package dom_prep_pkg;

   localparam int unsigned LfsrWidth           = 32;
   // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [LfsrWidth-1:0] LfsrTaps   = 32'h8020_0003;
   localparam int unsigned LfsrStepsPerAdvance = 3;
   localparam int unsigned WarmupCyclesDefault = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } prep_state_e;

   // Three Galois steps: shift right, fold the tap mask back in when a one drops out.
   function automatic logic [LfsrWidth-1:0] lfsr_advance(input logic [LfsrWidth-1:0] s);
      logic [LfsrWidth-1:0] v;
      v = s;
      for (int unsigned i = 0; i < LfsrStepsPerAdvance; i++) begin
         v = {1'b0, v[LfsrWidth-1:1]} ^ (v[0] ? LfsrTaps : '0);
      end
      return v;
   endfunction

endpackage

// File: rtl/dom_lfsr32.sv
// 32-bit Galois LFSR; a load wins over an advance, each advance is three steps.
module dom_lfsr32
   import dom_prep_pkg::*;
#(
   parameter logic [LfsrWidth-1:0] DEFAULT_SEED = 32'h0000_0001
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [LfsrWidth-1:0] seed,
   input  logic                 advance,
   output logic [LfsrWidth-1:0] state
);

   logic [LfsrWidth-1:0] state_q, state_d;

   // Next state: seed load, three-step advance, or hold.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seed;
      end else if (advance) begin
         state_d = lfsr_advance(state_q);
      end
   end

   // State register, returns to the default seed on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DEFAULT_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/dom_indep_d1_prep.sv
// First-order DOM input preparation: splits unshared a/b into two Boolean shares each and
// supplies one fresh random bit for the downstream DOM AND gadget.
// Build option DOM_PREP_RESEED_EN: exposes seed_valid/seed for runtime reseeding; without it the
// block self-seeds with DEFAULT_SEED on the first clock after reset release.
module dom_indep_d1_prep
   import dom_prep_pkg::*;
#(
   parameter int unsigned          WARMUP_CYCLES = WarmupCyclesDefault,
   parameter logic [LfsrWidth-1:0] DEFAULT_SEED  = 32'h0000_0001
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_a,
   input  logic                 in_b,
   output logic                 ready,
`ifdef DOM_PREP_RESEED_EN
   input  logic                 seed_valid,
   input  logic [LfsrWidth-1:0] seed,
`endif
   output logic                 out_valid,
   output logic [1:0]           port_a,
   output logic [1:0]           port_b,
   output logic                 port_r
);

   localparam int unsigned    CntW    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WARMUP_CYCLES - 1);

   prep_state_e          state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 seed_load;
   logic [LfsrWidth-1:0] seed_word;
   logic [LfsrWidth-1:0] lfsr_seed;
   logic                 lfsr_load;
   logic                 lfsr_adv;
   logic [LfsrWidth-1:0] lfsr_state;
   logic                 unused_lfsr;
   logic                 xfer;

   logic       out_valid_q, out_valid_d;
   logic [1:0] port_a_q, port_a_d;
   logic [1:0] port_b_q, port_b_d;
   logic       port_r_q, port_r_d;

`ifdef DOM_PREP_RESEED_EN
   assign seed_load = seed_valid;
   assign seed_word = seed;
`else
   // IDLE is only reachable through reset, so this is a one-shot load after release.
   assign seed_load = (state_q == IDLE);
   assign seed_word = DEFAULT_SEED;
`endif

   // An all-zero seed would lock the LFSR, substitute the default.
   assign lfsr_seed = (seed_word == '0) ? DEFAULT_SEED : seed_word;

   dom_lfsr32 #(
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (lfsr_seed),
      .advance (lfsr_adv),
      .state   (lfsr_state)
   );

   // Only the three low bits are consumed per cycle.
   assign unused_lfsr = ^lfsr_state[LfsrWidth-1:3];

   assign ready = (state_q == RUN);
   assign xfer  = in_valid & ready;

   // FSM next state, warmup counting and LFSR control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (seed_load) begin
               state_d   = WARMUP;
               cnt_d     = '0;
               lfsr_load = 1'b1;
            end
         end
         WARMUP: begin
            lfsr_adv = 1'b1;
            if (seed_load) begin
               cnt_d     = '0;
               lfsr_load = 1'b1;
            end else if (cnt_q == CntLast) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RUN: begin
            lfsr_adv = 1'b1;
            // A coincident transfer still samples the pre-load bits below.
            if (seed_load) begin
               state_d   = WARMUP;
               cnt_d     = '0;
               lfsr_load = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Share outputs: mask with LFSR bits on a transfer, otherwise hold.
   always_comb begin
      out_valid_d = xfer;
      port_a_d    = port_a_q;
      port_b_d    = port_b_q;
      port_r_d    = port_r_q;
      if (xfer) begin
         port_a_d = {lfsr_state[0], in_a ^ lfsr_state[0]};
         port_b_d = {lfsr_state[1], in_b ^ lfsr_state[1]};
         port_r_d = lfsr_state[2];
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         port_a_q    <= 2'b00;
         port_b_q    <= 2'b00;
         port_r_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         port_a_q    <= port_a_d;
         port_b_q    <= port_b_d;
         port_r_q    <= port_r_d;
      end
   end

   assign out_valid = out_valid_q;
   assign port_a    = port_a_q;
   assign port_b    = port_b_q;
   assign port_r    = port_r_q;

endmodule

// File: tb/tb_dom_indep_d1_prep.sv
// Directed + random bench for dom_indep_d1_prep against a cycle-level reference model.
// Works with or without DOM_PREP_RESEED_EN.
module tb_dom_indep_d1_prep;

   localparam int Warm = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_a = 1'b0;
   logic       in_b = 1'b0;
   logic       ready;
   logic       out_valid;
   logic [1:0] port_a;
   logic [1:0] port_b;
   logic       port_r;
`ifdef DOM_PREP_RESEED_EN
   logic        seed_valid = 1'b0;
   logic [31:0] seed = 32'h0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: LFSR value, warmup cycles left (-1 = idle, 0 = accepting), outputs.
   logic [31:0] m_lfsr;
   int          m_left;
   logic        m_ov;
   logic [1:0]  m_pa;
   logic [1:0]  m_pb;
   logic        m_r;

   dom_indep_d1_prep dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_a       (in_a),
      .in_b       (in_b),
      .ready      (ready),
`ifdef DOM_PREP_RESEED_EN
      .seed_valid (seed_valid),
      .seed       (seed),
`endif
      .out_valid  (out_valid),
      .port_a     (port_a),
      .port_b     (port_b),
      .port_r     (port_r)
   );

   always #5 clk = ~clk;

   // Multiply by x^-1 modulo x^32+x^22+x^2+x+1, three times.
   function automatic logic [31:0] ref_next(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int k = 0; k < 3; k++) begin
         if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
         else      v = v >> 1;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_lfsr = 32'h1;
      m_left = -1;
      m_ov   = 1'b0;
      m_pa   = 2'b00;
      m_pb   = 2'b00;
      m_r    = 1'b0;
   endtask

   // Apply one rising edge to the model using the inputs currently driven.
   task automatic model_edge();
      logic        go;
      logic        ld;
      logic [31:0] sd;
      if (rst) begin
         model_reset();
         return;
      end
      go = in_valid && (m_left == 0);
      m_ov = go;
      if (go) begin
         m_pa = {m_lfsr[0], in_a ^ m_lfsr[0]};
         m_pb = {m_lfsr[1], in_b ^ m_lfsr[1]};
         m_r  = m_lfsr[2];
      end
`ifdef DOM_PREP_RESEED_EN
      ld = seed_valid;
      sd = seed;
`else
      ld = (m_left == -1);
      sd = 32'h1;
`endif
      if (ld) begin
         m_lfsr = (sd == 32'h0) ? 32'h1 : sd;
         m_left = Warm;
      end else if (m_left != -1) begin
         m_lfsr = ref_next(m_lfsr);
         if (m_left > 0) m_left--;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".ready"}, 32'(ready), 32'(m_left == 0));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
      check({tag, ".port_a"}, 32'(port_a), 32'(m_pa));
      check({tag, ".port_b"}, 32'(port_b), 32'(m_pb));
      check({tag, ".port_r"}, 32'(port_r), 32'(m_r));
   endtask

   task automatic cyc(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   // Step until ready rises; compare the number of steps taken with exp.
   task automatic wait_ready(input string tag, input int exp);
      int n;
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         cyc(tag);
         if (ready === 1'b1) begin
            n = k;
            break;
         end
      end
      check({tag, ".latency"}, 32'(n), 32'(exp));
   endtask

   initial begin
      int   n_x;
      int   ones_a;
      int   ones_b;
      int   ones_r;
      logic go;
      logic cap_a;
      logic cap_b;

      // Reset values
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");

      // Release reset
      rst = 1'b0;
`ifdef DOM_PREP_RESEED_EN
      for (int k = 0; k < 100; k++) cyc("idle_hold");
      seed       = 32'h0;
      seed_valid = 1'b1;
      cyc("seed_zero_load");
      seed_valid = 1'b0;
      wait_ready("warmup_seed0", Warm);
`else
      wait_ready("warmup_implicit", Warm + 1);
`endif
      in_valid = 1'b1;
      in_a     = 1'b1;
      in_b     = 1'b0;
      cyc("first_xfer");
      check("first_xfer.valid", 32'(out_valid), 32'h1);

      // Random traffic
      n_x    = 0;
      ones_a = 0;
      ones_b = 0;
      ones_r = 0;
      for (int c = 0; c < 20000 && n_x < 10000; c++) begin
         in_valid = ($urandom_range(7) != 0);
         in_a     = 1'($urandom);
         in_b     = 1'($urandom);
         go       = in_valid && (m_left == 0);
         cap_a    = in_a;
         cap_b    = in_b;
         cyc("rand");
         if (go) begin
            n_x++;
            check("rand.xor_a", 32'(port_a[0] ^ port_a[1]), 32'(cap_a));
            check("rand.xor_b", 32'(port_b[0] ^ port_b[1]), 32'(cap_b));
            ones_a += int'(port_a[1]);
            ones_b += int'(port_b[1]);
            ones_r += int'(port_r);
         end
      end
      check("rand.count", 32'(n_x), 32'd10000);
      check("ratio_ma", 32'(ones_a * 50 >= n_x * 24 && ones_a * 50 <= n_x * 26), 32'h1);
      check("ratio_mb", 32'(ones_b * 50 >= n_x * 24 && ones_b * 50 <= n_x * 26), 32'h1);
      check("ratio_r", 32'(ones_r * 50 >= n_x * 24 && ones_r * 50 <= n_x * 26), 32'h1);

`ifdef DOM_PREP_RESEED_EN
      // Reseed coinciding with a transfer
      while (m_left != 0) cyc("to_run");
      in_valid   = 1'b1;
      in_a       = 1'b0;
      in_b       = 1'b1;
      seed       = $urandom | 32'h1;
      seed_valid = 1'b1;
      cyc("reseed_xfer");
      check("reseed_xfer.valid", 32'(out_valid), 32'h1);
      seed_valid = 1'b0;
      wait_ready("reseed_warmup", Warm);
`endif

      // Asynchronous reset in the middle of a transfer cycle
      in_valid = 1'b1;
      in_a     = 1'b1;
      in_b     = 1'b1;
      cyc("pre_rst_xfer");
      check("pre_rst_xfer.valid", 32'(out_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      cyc("rst_hold");
      cyc("rst_hold");
      rst = 1'b0;
`ifdef DOM_PREP_RESEED_EN
      for (int k = 0; k < 5; k++) cyc("post_rst_idle");
      seed       = $urandom;
      seed_valid = 1'b1;
      cyc("post_rst_seed");
      seed_valid = 1'b0;
      wait_ready("post_rst_warmup", Warm);
`else
      wait_ready("post_rst_warmup", Warm + 1);
`endif
      for (int k = 0; k < 50; k++) begin
         in_valid = 1'($urandom);
         in_a     = 1'($urandom);
         in_b     = 1'($urandom);
         cyc("post_rst_rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dom_indep_d1_prep.md
DOM_INDEP_D1_PREP -- requirements
Module: dom_indep_d1_prep

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 16, meaning number of LFSR advance cycles after any seed load before the first input is accepted.
REQ-002 SHALL have parameter DEFAULT_SEED, default 32'h0000_0001, meaning the seed used after reset, or in place of an all-zero seed.
REQ-003 SHALL have port clk, input, 1, sole clock; all flops update on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, unshared operand pair present.
REQ-006 SHALL have port in_a, input, 1, unshared operand a.
REQ-007 SHALL have port in_b, input, 1, unshared operand b.
REQ-008 SHALL have port ready, output, 1, block accepts in_a/in_b this cycle.
REQ-009 SHALL have port seed_valid, input, 1, load seed this cycle; present only with the macro of REQ-024.
REQ-010 SHALL have port seed, input, 32, new LFSR seed; present only with the macro of REQ-024.
REQ-011 SHALL have port out_valid, output, 1, shares and randomness valid for the downstream DOM AND gadget.
REQ-012 SHALL have port port_a, output, 2, two Boolean shares of a.
REQ-013 SHALL have port port_b, output, 2, two Boolean shares of b.
REQ-014 SHALL have port port_r, output, 1, fresh randomness for the DOM gadget.

Function
REQ-015 SHALL hold a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, which advances exactly 3 steps per clock cycle in every state except IDLE.
REQ-016 SHALL use the FSM states IDLE, WARMUP and RUN; ready = 1 only in RUN.
REQ-017 Transitions SHALL be: IDLE->WARMUP on seed load; WARMUP->RUN when the warmup counter reaches WARMUP_CYCLES-1; RUN->WARMUP on seed load; WARMUP->WARMUP with the counter cleared on seed load.
REQ-018 A seed load SHALL replace the LFSR state with seed, or with DEFAULT_SEED if seed == 0, and SHALL clear the warmup counter.
REQ-019 On a transfer (in_valid & ready), the block SHALL register, one cycle later: port_a = {m_a, in_a^m_a}; port_b = {m_b, in_b^m_b}; port_r = r; out_valid = 1.
REQ-020 m_a, m_b and r SHALL be bits [0], [1] and [2] of the LFSR state in the transfer cycle, before the update; each cycle uses fresh bits.
REQ-021 With no transfer, the block SHALL set out_valid = 0 the next cycle and hold the share outputs at their last values.
REQ-022 If in_valid and seed_valid are both asserted in RUN, the block SHALL accept the input using the pre-load LFSR bits, then load the seed and enter WARMUP.
REQ-023 in_valid while ready = 0 SHALL be ignored; it produces no out_valid.

Configuration
REQ-024 Macro DOM_PREP_RESEED_EN: when defined, the seed_valid and seed ports SHALL exist and drive REQ-017/REQ-018; when undefined, the ports SHALL be absent, the first clock after reset release SHALL perform an implicit load of DEFAULT_SEED, and RUN->WARMUP SHALL never occur.

Reset
REQ-025 With rst = 1, the block SHALL be in state IDLE with LFSR = DEFAULT_SEED, warmup counter = 0, ready = 0, out_valid = 0, port_a = 2'b00, port_b = 2'b00, port_r = 1'b0.
REQ-026 Asserting rst mid-WARMUP or mid-RUN SHALL immediately force the REQ-025 values and discard any pending output.

Structure
REQ-027 Package dom_prep_pkg SHALL hold: the LFSR width (32), the tap mask 32'h8020_0003, the state enum {IDLE, WARMUP, RUN}, and the default WARMUP_CYCLES value.
REQ-028 The LFSR SHALL be the sub-module dom_lfsr32, with ports clk, rst, load, seed, advance and state; it performs 3 steps per advance.

Verification
REQ-029 Release rst with the macro on and seed_valid held low for 100 cycles -> ready = 0 and out_valid = 0 throughout.
REQ-030 Load seed = 32'h0 -> LFSR = 32'h1; ready rises exactly 16 cycles after the load; the first transfer gives out_valid = 1 one cycle later.
REQ-031 Run 10,000 random transfers in RUN -> every out_valid cycle satisfies port_a[0]^port_a[1] = in_a and port_b[0]^port_b[1] = in_b; m_a, m_b and r each have a ones-ratio of 0.5 +/- 0.02; all three match a reference LFSR model.
REQ-032 Assert seed_valid and in_valid in the same RUN cycle -> that input still gives out_valid = 1 next cycle, then ready = 0 for 16 cycles.
REQ-033 Assert rst during a transfer cycle -> out_valid = 0 and all share outputs = 0 immediately; no out_valid occurs after release until the warmup completes.
REQ-034 Compile with the macro off -> ready rises 17 cycles after rst release, and the output sequence matches the model seeded with 32'h1.
